// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction-fetch stage with a small prefetch queue.
// Issues sequential IM reads ahead of decode, buffers returned instructions
// together with their PC+1, drops wrong-path responses after a redirect and
// feeds the IF/ID pipeline register.
// Optional feature macro: IFQ_BYPASS_EN (response loads IF/ID directly when
// the queue is empty, saving one cycle of fetch latency).
module if_prefetch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PC_src_i,
  input  logic [ADDR_WIDTH-1:0] branchAddr_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
  input  logic                  flushIF_ID_i,
  input  logic                  stallIF_ID_i,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic                  im_rd_o,
  input  logic                  im_gnt_i,
  input  logic [DATA_WIDTH-1:0] im_rdata_i,
  input  logic                  im_valid_i,
  output logic [DATA_WIDTH-1:0] instrD_IF_ID_rd_o,
  output logic [ADDR_WIDTH-1:0] PCD_IF_ID_rd_o,
  output logic                  validD_IF_ID_rd_o
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]         DEPTH_C = (CW+1)'(FQ_DEPTH);
  localparam logic [CW-1:0]       ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0]       ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]       ONE_P   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Architectural state
  logic [ADDR_WIDTH-1:0] pc_r, pc_nx_s;
  logic [CW-1:0]         outst_r, outst_nx_s;
  logic [CW-1:0]         drop_cnt_r, drop_nx_s;
  logic [CW-1:0]         q_count_r, q_count_nx_s;
  logic [PW-1:0]         wr_ptr_r, wr_ptr_nx_s, rd_ptr_r, rd_ptr_nx_s;
  logic [DATA_WIDTH-1:0] q_instr_r [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pcd_r   [FQ_DEPTH];
  logic [DATA_WIDTH-1:0] ifid_instr_r, ifid_instr_nx_s;
  logic [ADDR_WIDTH-1:0] ifid_pcd_r, ifid_pcd_nx_s;
  logic                  ifid_valid_r, ifid_valid_nx_s;

  // Per-cycle decisions
  logic                  redirect_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic                  issue_s, grant_s, resp_keep_s, bypass_s;
  logic                  push_s, pop_s, q_empty_s;
  logic [CW-1:0]         grant_c_s, valid_c_s;
  logic [ADDR_WIDTH-1:0] resp_pcd_s;

  assign redirect_s = PC_src_i | jump_i;
  assign target_s   = PC_src_i ? branchAddr_i : jumpAddr_i;
  // Request while the queue plus in-flight reads still fit; never in reset
  // or on a redirect cycle, so a grant can never carry a wrong-path address.
  assign issue_s    = rst & ~redirect_s &
                      (({1'b0, q_count_r} + {1'b0, outst_r}) < DEPTH_C);
  assign grant_s    = issue_s & im_gnt_i;
  assign grant_c_s  = {{(CW-1){1'b0}}, grant_s};
  assign valid_c_s  = {{(CW-1){1'b0}}, im_valid_i};
  assign q_empty_s  = (q_count_r == ZERO_C);
  assign resp_keep_s = im_valid_i & ~redirect_s & (drop_cnt_r == ZERO_C);
  // Fetch is sequential and responses are in order, so the oldest live
  // request was issued at pc - outstanding; no address FIFO is needed.
  assign resp_pcd_s = pc_r - ADDR_WIDTH'(outst_r) + ONE_A;

`ifdef IFQ_BYPASS_EN
  assign bypass_s = resp_keep_s & q_empty_s & ~stallIF_ID_i & ~flushIF_ID_i;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s = resp_keep_s & ~bypass_s;
  assign pop_s  = ~stallIF_ID_i & ~flushIF_ID_i & ~q_empty_s;

  assign im_rd_o   = issue_s;
  assign im_addr_o = pc_r;

  assign instrD_IF_ID_rd_o = ifid_instr_r;
  assign PCD_IF_ID_rd_o    = ifid_pcd_r;
  assign validD_IF_ID_rd_o = ifid_valid_r;

  // Next-state for PC, request/drop counters and queue pointers
  always_comb begin
    pc_nx_s      = pc_r;
    outst_nx_s   = outst_r + grant_c_s - valid_c_s;
    drop_nx_s    = drop_cnt_r;
    q_count_nx_s = q_count_r;
    wr_ptr_nx_s  = wr_ptr_r;
    rd_ptr_nx_s  = rd_ptr_r;
    if (redirect_s) begin
      pc_nx_s = target_s;
    end else if (grant_s) begin
      pc_nx_s = pc_r + ONE_A;
    end else begin
      pc_nx_s = pc_r;
    end
    if (redirect_s) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_nx_s = outst_r - valid_c_s;
    end else if (im_valid_i && (drop_cnt_r != ZERO_C)) begin
      drop_nx_s = drop_cnt_r - ONE_C;
    end else begin
      drop_nx_s = drop_cnt_r;
    end
    if (redirect_s) begin
      q_count_nx_s = ZERO_C;
      wr_ptr_nx_s  = {PW{1'b0}};
      rd_ptr_nx_s  = {PW{1'b0}};
    end else begin
      wr_ptr_nx_s = push_s ? (wr_ptr_r + ONE_P) : wr_ptr_r;
      rd_ptr_nx_s = pop_s  ? (rd_ptr_r + ONE_P) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   q_count_nx_s = q_count_r + ONE_C;
        2'b01:   q_count_nx_s = q_count_r - ONE_C;
        default: q_count_nx_s = q_count_r;
      endcase
    end
  end

  // Next-state for the IF/ID register: stall > flush > queue head > bypass > bubble
  always_comb begin
    ifid_instr_nx_s = ifid_instr_r;
    ifid_pcd_nx_s   = ifid_pcd_r;
    ifid_valid_nx_s = ifid_valid_r;
    if (stallIF_ID_i) begin
      ifid_instr_nx_s = ifid_instr_r;
      ifid_pcd_nx_s   = ifid_pcd_r;
      ifid_valid_nx_s = ifid_valid_r;
    end else if (flushIF_ID_i) begin
      ifid_instr_nx_s = {DATA_WIDTH{1'b0}};
      ifid_pcd_nx_s   = {ADDR_WIDTH{1'b0}};
      ifid_valid_nx_s = 1'b0;
    end else if (!q_empty_s) begin
      ifid_instr_nx_s = q_instr_r[rd_ptr_r];
      ifid_pcd_nx_s   = q_pcd_r[rd_ptr_r];
      ifid_valid_nx_s = 1'b1;
    end else if (bypass_s) begin
      ifid_instr_nx_s = im_rdata_i;
      ifid_pcd_nx_s   = resp_pcd_s;
      ifid_valid_nx_s = 1'b1;
    end else begin
      ifid_instr_nx_s = {DATA_WIDTH{1'b0}};
      ifid_pcd_nx_s   = {ADDR_WIDTH{1'b0}};
      ifid_valid_nx_s = 1'b0;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r         <= RESET_PC;
      outst_r      <= ZERO_C;
      drop_cnt_r   <= ZERO_C;
      q_count_r    <= ZERO_C;
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      ifid_instr_r <= {DATA_WIDTH{1'b0}};
      ifid_pcd_r   <= {ADDR_WIDTH{1'b0}};
      ifid_valid_r <= 1'b0;
    end else begin
      pc_r         <= pc_nx_s;
      outst_r      <= outst_nx_s;
      drop_cnt_r   <= drop_nx_s;
      q_count_r    <= q_count_nx_s;
      wr_ptr_r     <= wr_ptr_nx_s;
      rd_ptr_r     <= rd_ptr_nx_s;
      ifid_instr_r <= ifid_instr_nx_s;
      ifid_pcd_r   <= ifid_pcd_nx_s;
      ifid_valid_r <= ifid_valid_nx_s;
    end
  end

  // Queue storage; occupancy is tracked by the counters, so data needs no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_instr_r[wr_ptr_r] <= im_rdata_i;
      q_pcd_r[wr_ptr_r]   <= resp_pcd_s;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: directed phases followed by randomized traffic, all
// checked every cycle against a queue-based reference model of the fetch unit
// and an in-order variable-latency instruction memory.
module tb_if_prefetch_unit;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int D  = 4;
  localparam logic [AW-1:0] RPC = 8'hFE;

  logic          clk = 1'b0;
  logic          rst;
  logic          PC_src_i, jump_i, flushIF_ID_i, stallIF_ID_i;
  logic [AW-1:0] branchAddr_i, jumpAddr_i;
  logic [AW-1:0] im_addr_o;
  logic          im_rd_o, im_gnt_i, im_valid_i;
  logic [DW-1:0] im_rdata_i;
  logic [DW-1:0] instrD_IF_ID_rd_o;
  logic [AW-1:0] PCD_IF_ID_rd_o;
  logic          validD_IF_ID_rd_o;

  if_prefetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FQ_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .PC_src_i(PC_src_i), .branchAddr_i(branchAddr_i),
    .jump_i(jump_i), .jumpAddr_i(jumpAddr_i),
    .flushIF_ID_i(flushIF_ID_i), .stallIF_ID_i(stallIF_ID_i),
    .im_addr_o(im_addr_o), .im_rd_o(im_rd_o), .im_gnt_i(im_gnt_i),
    .im_rdata_i(im_rdata_i), .im_valid_i(im_valid_i),
    .instrD_IF_ID_rd_o(instrD_IF_ID_rd_o), .PCD_IF_ID_rd_o(PCD_IF_ID_rd_o),
    .validD_IF_ID_rd_o(validD_IF_ID_rd_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic stale; } req_t;
  typedef struct packed { logic [DW-1:0] instr; logic [AW-1:0] pcd; } ent_t;
  typedef struct packed { logic [DW-1:0] data; int unsigned due; } rsp_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [AW-1:0] m_pc;
  ent_t          fq[$];
  req_t          inflight[$];
  logic [DW-1:0] m_instr;
  logic [AW-1:0] m_pcd;
  logic          m_valid;
  // Memory model state
  rsp_t          impipe[$];
  int unsigned   last_due;
  int unsigned   cyc = 0;
  int            lat_lo = 1, lat_hi = 1;
  logic [AW-1:0] seen[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    PC_src_i = 1'b0; jump_i = 1'b0; flushIF_ID_i = 1'b0; stallIF_ID_i = 1'b0;
    branchAddr_i = 8'h00; jumpAddr_i = 8'h00; im_gnt_i = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; im_gnt_i = 1'b0; im_valid_i = 1'b0; im_rdata_i = 16'h0000;
    #1;
    chk("rd_in_reset", {31'd0, im_rd_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    m_pc = RPC; fq.delete(); inflight.delete(); impipe.delete(); last_due = 0;
    m_instr = 16'h0000; m_pcd = 8'h00; m_valid = 1'b0;
    chk("rst_instr", {16'd0, instrD_IF_ID_rd_o}, 32'd0);
    chk("rst_pcd",   {24'd0, PCD_IF_ID_rd_o}, 32'd0);
    chk("rst_valid", {31'd0, validD_IF_ID_rd_o}, 32'd0);
    chk("rst_rd",    {31'd0, im_rd_o}, 32'd0);
    rst = 1'b1; im_gnt_i = 1'b1;
  endtask

  // One clock cycle: memory response, request check, edge, model update, IF/ID check
  task automatic cycle();
    logic red, grant, exp_rd, keep, bypassed;
    logic [AW-1:0] tgt;
    req_t r;
    rsp_t p;
    int unsigned due;
    if (impipe.size() > 0 && impipe[0].due <= cyc) begin
      p = impipe.pop_front();
      im_valid_i = 1'b1; im_rdata_i = p.data;
    end else begin
      im_valid_i = 1'b0; im_rdata_i = DW'($urandom);
    end
    #1;
    red    = PC_src_i | jump_i;
    tgt    = PC_src_i ? branchAddr_i : jumpAddr_i;
    exp_rd = !red && (fq.size() + inflight.size() < D);
    chk("im_rd", {31'd0, im_rd_o}, {31'd0, exp_rd});
    if (exp_rd) chk("im_addr", {24'd0, im_addr_o}, {24'd0, m_pc});
    grant = exp_rd && im_gnt_i;
    if (grant) begin
      due = cyc + int'($urandom_range(lat_lo, lat_hi));
      if (last_due + 1 > due) due = last_due + 1;
      last_due = due;
      p.data = mem_word(im_addr_o); p.due = due;
      impipe.push_back(p);
    end
    @(posedge clk);
    // Reference model update
    keep = 1'b0;
    r = '0;
    if (im_valid_i) begin
      r = inflight.pop_front();
      keep = !red && !r.stale;
    end
    bypassed = 1'b0;
    if (!stallIF_ID_i) begin
      if (flushIF_ID_i) begin
        m_instr = 16'h0000; m_pcd = 8'h00; m_valid = 1'b0;
      end else if (fq.size() > 0) begin
        ent_t e;
        e = fq.pop_front();
        m_instr = e.instr; m_pcd = e.pcd; m_valid = 1'b1;
`ifdef IFQ_BYPASS_EN
      end else if (keep) begin
        m_instr = mem_word(r.addr); m_pcd = r.addr + 8'h01; m_valid = 1'b1;
        bypassed = 1'b1;
`endif
      end else begin
        m_instr = 16'h0000; m_pcd = 8'h00; m_valid = 1'b0;
      end
    end
    if (red) begin
      fq.delete();
      for (int i = 0; i < inflight.size(); i++) begin
        req_t t;
        t = inflight[i]; t.stale = 1'b1; inflight[i] = t;
      end
      m_pc = tgt;
    end else if (keep && !bypassed) begin
      fq.push_back({mem_word(r.addr), r.addr + 8'h01});
    end
    if (grant) begin
      inflight.push_back({m_pc, 1'b0});
      m_pc = m_pc + 8'h01;
    end
    cyc++;
    #1;
    chk("ifid_instr", {16'd0, instrD_IF_ID_rd_o}, {16'd0, m_instr});
    chk("ifid_pcd",   {24'd0, PCD_IF_ID_rd_o}, {24'd0, m_pcd});
    chk("ifid_valid", {31'd0, validD_IF_ID_rd_o}, {31'd0, m_valid});
    if (validD_IF_ID_rd_o === 1'b1) seen.push_back(PCD_IF_ID_rd_o);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      im_gnt_i     = ($urandom_range(0, 3) != 0);
      stallIF_ID_i = ($urandom_range(0, 4) == 0);
      flushIF_ID_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        PC_src_i = $urandom_range(0, 1) == 1;
        jump_i   = !PC_src_i || ($urandom_range(0, 1) == 1);
        branchAddr_i = AW'($urandom); jumpAddr_i = AW'($urandom);
        flushIF_ID_i = 1'b1;
      end
      cycle();
    end
  endtask

  initial begin
    set_idle();
    do_reset();

    // Streaming from RESET_PC=0xFE with latency 1: PCD FF, 00, 01
    lat_lo = 1; lat_hi = 1;
    seen.delete();
    repeat (8) cycle();
    chk("wrap_pcd0", {24'd0, seen[0]}, 32'hFF);
    chk("wrap_pcd1", {24'd0, seen[1]}, 32'h00);
    chk("wrap_pcd2", {24'd0, seen[2]}, 32'h01);

    // Hold IF/ID for 10 cycles: queue fills, requests stop, then drains in order
    stallIF_ID_i = 1'b1;
    repeat (10) cycle();
    #1;
    chk("stall_rd_low", {31'd0, im_rd_o}, 32'd0);
    stallIF_ID_i = 1'b0;
    seen.delete();
    repeat (4) cycle();
    chk("drain_no_bubble", seen.size(), 32'd4);

    // Branch with IM latency 3 and requests in flight
    lat_lo = 3; lat_hi = 3;
    repeat (3) cycle();
    PC_src_i = 1'b1; branchAddr_i = 8'h40; flushIF_ID_i = 1'b1;
    seen.delete();
    cycle();
    set_idle();
    repeat (10) cycle();
    chk("branch_first_pcd", {24'd0, seen[0]}, 32'h41);

    // Branch and jump together: branch wins
    lat_lo = 1; lat_hi = 1;
    PC_src_i = 1'b1; jump_i = 1'b1; branchAddr_i = 8'h10; jumpAddr_i = 8'h20;
    flushIF_ID_i = 1'b1;
    seen.delete();
    cycle();
    set_idle();
    repeat (5) cycle();
    chk("prio_first_pcd", {24'd0, seen[0]}, 32'h11);

    // Flush with stall holds; flush alone bubbles and keeps the queue head
    stallIF_ID_i = 1'b1;
    repeat (6) cycle();
    flushIF_ID_i = 1'b1;
    cycle();
    chk("flush_stall_hold", {31'd0, validD_IF_ID_rd_o}, 32'd1);
    stallIF_ID_i = 1'b0;
    cycle();
    chk("flush_bubble_valid", {31'd0, validD_IF_ID_rd_o}, 32'd0);
    chk("flush_bubble_instr", {16'd0, instrD_IF_ID_rd_o}, 32'd0);
    set_idle();
    repeat (6) cycle();

    // Randomized traffic, mid-run reset, more traffic
    lat_lo = 1; lat_hi = 4;
    random_run(800);
    set_idle();
    do_reset();
    random_run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
